// File: rtl/music_pkg.sv
// -----------------------------------------------------------------------------
// music_pkg
// Shared definitions for the ROM-driven buzzer sequencer:
//   - state_e      : sequencer state encoding
//   - DEF_*        : default clock / beat figures (UNIT = CLK_FRE / BEAT_DIV)
//   - calc_unit()  : duration unit in clock cycles for a given clock/beat pair
//   - vol_shift()  : volume code -> right-shift applied to the tone period
//                    to form the low-time threshold (duty control)
// -----------------------------------------------------------------------------
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned DEF_CLK_FRE  = 32'd50_000_000;
  localparam int unsigned DEF_BEAT_DIV = 32'd8;
  localparam int unsigned DEF_UNIT     = DEF_CLK_FRE / DEF_BEAT_DIV;

  // Loudest duty is 1/2 (vol 4); codes above that saturate.
  localparam logic [2:0] VOL_MAX        = 3'd4;
  localparam logic [2:0] VOL_SHIFT_BASE = 3'd5;

  // Clock cycles per duration unit; a zero divider degrades to one unit per second.
  function automatic int unsigned calc_unit(input int unsigned clk_fre,
                                            input int unsigned beat_div);
    int unsigned unit;
    if (beat_div == 32'd0) begin
      unit = clk_fre;
    end else begin
      unit = clk_fre / beat_div;
    end
    return unit;
  endfunction

  // vol 1..4 -> shift 4..1 (duty 1/16 .. 1/2); vol 0 is muted elsewhere.
  function automatic logic [2:0] vol_shift(input logic [2:0] vol);
    logic [2:0] v;
    if (vol > VOL_MAX) begin
      v = VOL_MAX;
    end else begin
      v = vol;
    end
    return VOL_SHIFT_BASE - v;
  endfunction

endpackage

// File: rtl/music_tone_gen.sv
// -----------------------------------------------------------------------------
// music_tone_gen
// Square-wave generator for one note. hz_cnt runs 0..cycle-1 while enabled
// and is frozen otherwise; load restarts the phase at 0. The registered,
// active-low buzzer is low while hz_cnt < (cycle >> vol_shift(vol)).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cycle      : tone period in clock cycles (0 = rest)
//   vol        : volume code (0 = mute)
//   enable     : advance the tone this cycle (PLAY and running)
//   load       : restart phase for a new note
//   buzzer     : registered active-low drive, 1 when silent
// -----------------------------------------------------------------------------
module music_tone_gen
  import music_pkg::*;
#(
  parameter int CYC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CYC_W-1:0] cycle,
  input  logic [2:0]       vol,
  input  logic             enable,
  input  logic             load,
  output logic             buzzer
);

  localparam logic [CYC_W-1:0] CNT_ZERO = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CNT_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};

  logic [CYC_W-1:0] hz_cnt_q, hz_cnt_d;
  logic             buzzer_q, buzzer_d;
  logic [CYC_W-1:0] thr_s;
  logic             at_end_s;

  // Phase counter update and duty compare for the next buzzer value.
  always_comb begin
    thr_s    = cycle >> vol_shift(vol);
    at_end_s = (cycle == CNT_ZERO) || (hz_cnt_q >= (cycle - CNT_ONE));

    hz_cnt_d = hz_cnt_q;
    if (load) begin
      hz_cnt_d = CNT_ZERO;
    end else if (enable) begin
      if (at_end_s) begin
        hz_cnt_d = CNT_ZERO;
      end else begin
        hz_cnt_d = hz_cnt_q + CNT_ONE;
      end
    end else begin
      hz_cnt_d = hz_cnt_q;
    end

    buzzer_d = 1'b1;
    if (enable && (vol != 3'd0) && (cycle != CNT_ZERO) && (hz_cnt_q < thr_s)) begin
      buzzer_d = 1'b0;
    end else begin
      buzzer_d = 1'b1;
    end
  end

  // Phase and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_cnt_q <= CNT_ZERO;
      buzzer_q <= 1'b1;
    end else begin
      hz_cnt_q <= hz_cnt_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign buzzer = buzzer_q;

endmodule

// File: rtl/music_seq_player.sv
// -----------------------------------------------------------------------------
// music_seq_player
// Steps through an external note ROM (period + duration per entry) and drives
// an active-low buzzer. Supports pause (run=0), abort (stop), looping, a
// silent articulation gap after each note, volume (duty), rests (cycle 0)
// and skipped entries (dur 0). Song length is sampled live at each advance.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   play_en             : start pulse, honoured in IDLE only
//   run                 : 1 play, 0 pause
//   stop                : abort pulse, highest priority
//   loop_en             : wrap to note 0 after the last note
//   song_len            : number of notes (0 = empty song)
//   vol                 : 0 mute, 1..4 duty 1/16..1/2, 5..7 as 4
//   rom_addr            : note ROM address (registered)
//   rom_cycle, rom_dur  : ROM data, valid ROM_LAT cycles after rom_addr
//   buzzer              : active-low drive, idle 1
//   busy                : 1 outside IDLE
//   play_done           : one-cycle pulse at song end (non-loop)
//   song_wrap           : one-cycle pulse when the song wraps
// -----------------------------------------------------------------------------
module music_seq_player
  import music_pkg::*;
#(
  parameter int CLK_FRE  = 50_000_000,
  parameter int BEAT_DIV = 8,
  parameter int ADDR_W   = 9,
  parameter int DUR_W    = 8,
  parameter int CYC_W    = 20,
  parameter int ROM_LAT  = 1,
  parameter int GAP_CYC  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play_en,
  input  logic              run,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W:0]   song_len,
  input  logic [2:0]        vol,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CYC_W-1:0]  rom_cycle,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic              buzzer,
  output logic              busy,
  output logic              play_done,
  output logic              song_wrap
);

  localparam logic [31:0]       UNIT      = 32'(calc_unit(CLK_FRE, BEAT_DIV));
  localparam logic [31:0]       GAP_LOAD  = 32'(GAP_CYC);
  localparam logic [1:0]        LAT       = 2'(ROM_LAT);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0]  CYC_ZERO  = {CYC_W{1'b0}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]        fetch_cnt_q, fetch_cnt_d;
  logic [31:0]       dur_cnt_q, dur_cnt_d;
  logic [31:0]       gap_cnt_q, gap_cnt_d;
  logic [CYC_W-1:0]  note_cycle_q, note_cycle_d;
  logic              busy_q, busy_d;
  logic              play_done_q, play_done_d;
  logic              song_wrap_q, song_wrap_d;

  logic              tone_load_s;
  logic              tone_en_s;
  logic [ADDR_W:0]   addr_inc_s;
  state_e            adv_state_s;
  logic [ADDR_W-1:0] adv_addr_s;
  logic              adv_wrap_s;

  // End-of-note decision: next note, wrap to note 0, or finish.
  always_comb begin
    addr_inc_s = {1'b0, rom_addr_q} + LEN_ONE;
    if (addr_inc_s < song_len) begin
      adv_state_s = ST_FETCH;
      adv_addr_s  = addr_inc_s[ADDR_W-1:0];
      adv_wrap_s  = 1'b0;
    end else if (loop_en) begin
      adv_state_s = ST_FETCH;
      adv_addr_s  = ADDR_ZERO;
      adv_wrap_s  = 1'b1;
    end else begin
      adv_state_s = ST_DONE;
      adv_addr_s  = rom_addr_q;
      adv_wrap_s  = 1'b0;
    end
  end

  // Sequencer next-state, counters and address.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    fetch_cnt_d  = fetch_cnt_q;
    dur_cnt_d    = dur_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    note_cycle_d = note_cycle_q;
    song_wrap_d  = 1'b0;
    tone_load_s  = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      rom_addr_d  = ADDR_ZERO;
      fetch_cnt_d = 2'd0;
      dur_cnt_d   = 32'd0;
      gap_cnt_d   = 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play_en) begin
            if (song_len != LEN_ZERO) begin
              state_d     = ST_FETCH;
              rom_addr_d  = ADDR_ZERO;
              fetch_cnt_d = 2'd0;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_FETCH: begin
          // ROM data for rom_addr_q is valid once LAT cycles have elapsed.
          if (fetch_cnt_q >= LAT) begin
            fetch_cnt_d  = 2'd0;
            note_cycle_d = rom_cycle;
            if (rom_dur == {DUR_W{1'b0}}) begin
              state_d     = adv_state_s;
              rom_addr_d  = adv_addr_s;
              song_wrap_d = adv_wrap_s;
            end else begin
              state_d     = ST_PLAY;
              dur_cnt_d   = 32'(rom_dur) * UNIT;
              tone_load_s = 1'b1;
            end
          end else begin
            fetch_cnt_d = fetch_cnt_q + 2'd1;
          end
        end

        ST_PLAY: begin
          if (run) begin
            if (dur_cnt_q <= 32'd1) begin
              dur_cnt_d = 32'd0;
              if (GAP_LOAD != 32'd0) begin
                state_d   = ST_GAP;
                gap_cnt_d = GAP_LOAD;
              end else begin
                state_d     = adv_state_s;
                rom_addr_d  = adv_addr_s;
                song_wrap_d = adv_wrap_s;
              end
            end else begin
              dur_cnt_d = dur_cnt_q - 32'd1;
            end
          end else begin
            dur_cnt_d = dur_cnt_q;
          end
        end

        ST_GAP: begin
          if (run) begin
            if (gap_cnt_q <= 32'd1) begin
              gap_cnt_d   = 32'd0;
              state_d     = adv_state_s;
              rom_addr_d  = adv_addr_s;
              song_wrap_d = adv_wrap_s;
            end else begin
              gap_cnt_d = gap_cnt_q - 32'd1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d    = ST_IDLE;
          rom_addr_d = ADDR_ZERO;
        end
      endcase
    end

    busy_d      = (state_d != ST_IDLE);
    play_done_d = (state_d == ST_DONE);
    // stop also silences the tone so buzzer is 1 on the following cycle.
    tone_en_s   = (state_q == ST_PLAY) && run && !stop;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rom_addr_q   <= ADDR_ZERO;
      fetch_cnt_q  <= 2'd0;
      dur_cnt_q    <= 32'd0;
      gap_cnt_q    <= 32'd0;
      note_cycle_q <= CYC_ZERO;
      busy_q       <= 1'b0;
      play_done_q  <= 1'b0;
      song_wrap_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      fetch_cnt_q  <= fetch_cnt_d;
      dur_cnt_q    <= dur_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      note_cycle_q <= note_cycle_d;
      busy_q       <= busy_d;
      play_done_q  <= play_done_d;
      song_wrap_q  <= song_wrap_d;
    end
  end

  music_tone_gen #(
    .CYC_W (CYC_W)
  ) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .cycle  (note_cycle_q),
    .vol    (vol),
    .enable (tone_en_s),
    .load   (tone_load_s),
    .buzzer (buzzer)
  );

  assign rom_addr  = rom_addr_q;
  assign busy      = busy_q;
  assign play_done = play_done_q;
  assign song_wrap = song_wrap_q;

endmodule

// File: tb/tb_music_seq_player.sv
// -----------------------------------------------------------------------------
// tb_music_seq_player
// Directed bench for music_seq_player with UNIT=100 cycles, GAP=10 cycles and
// a 1-cycle registered note ROM. Inputs change and outputs are observed on the
// falling clock edge. Cycle c0 is the edge where play_en is raised; the note
// fetch occupies c1..c2, the first note plays c3.., and the registered buzzer
// shows each PLAY cycle's tone one cycle later.
// -----------------------------------------------------------------------------
module tb_music_seq_player;

  localparam int ADDR_W = 9;
  localparam int DUR_W  = 8;
  localparam int CYC_W  = 20;

  logic              clk;
  logic              rst_n;
  logic              play_en;
  logic              run;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W:0]   song_len;
  logic [2:0]        vol;
  logic [ADDR_W-1:0] rom_addr;
  logic [CYC_W-1:0]  rom_cycle;
  logic [DUR_W-1:0]  rom_dur;
  logic              buzzer;
  logic              busy;
  logic              play_done;
  logic              song_wrap;

  logic [CYC_W-1:0]  rom_c [0:(1<<ADDR_W)-1];
  logic [DUR_W-1:0]  rom_d [0:(1<<ADDR_W)-1];

  int total;
  int bad;
  int done_seen;
  int wrap_seen;
  int d0;
  int w0;

  music_seq_player #(
    .CLK_FRE  (1600),
    .BEAT_DIV (16),
    .ADDR_W   (ADDR_W),
    .DUR_W    (DUR_W),
    .CYC_W    (CYC_W),
    .ROM_LAT  (1),
    .GAP_CYC  (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .play_en   (play_en),
    .run       (run),
    .stop      (stop),
    .loop_en   (loop_en),
    .song_len  (song_len),
    .vol       (vol),
    .rom_addr  (rom_addr),
    .rom_cycle (rom_cycle),
    .rom_dur   (rom_dur),
    .buzzer    (buzzer),
    .busy      (busy),
    .play_done (play_done),
    .song_wrap (song_wrap)
  );

  always #5 clk = ~clk;

  // Registered note ROM, one cycle of latency.
  always @(posedge clk) begin
    rom_cycle <= rom_c[rom_addr];
    rom_dur   <= rom_d[rom_addr];
  end

  // Pulse counters.
  always @(posedge clk) begin
    if (play_done) done_seen <= done_seen + 1;
    if (song_wrap) wrap_seen <= wrap_seen + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n buzzer samples of a tone with given period/low-time, starting at phase ph0.
  task automatic tone(input int n, input int per, input int low, input int ph0, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, {31'd0, buzzer}, (((ph0 + i) % per) < low) ? 32'd0 : 32'd1);
    end
  endtask

  // Starting one cycle after the last tone sample: gap, DONE pulse, IDLE.
  task automatic finish_song(input string tag);
    for (int i = 0; i < 9; i++) begin
      tick();
      check({tag, "_gap_buz"}, {31'd0, buzzer}, 32'd1);
      check({tag, "_gap_done"}, {31'd0, play_done}, 32'd0);
    end
    tick();
    check({tag, "_done"}, {31'd0, play_done}, 32'd1);
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, "_after_done"}, {31'd0, play_done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic start();
    play_en = 1'b1;
    tick();
    play_en = 1'b0;
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    play_en   = 1'b0;
    run       = 1'b1;
    stop      = 1'b0;
    loop_en   = 1'b0;
    song_len  = '0;
    vol       = 3'd4;
    total     = 0;
    bad       = 0;
    done_seen = 0;
    wrap_seen = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      rom_c[i] = '0;
      rom_d[i] = '0;
    end

    // Reset values
    tick();
    tick();
    check("rst_buzzer", {31'd0, buzzer}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, play_done}, 32'd0);
    check("rst_wrap", {31'd0, song_wrap}, 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Normal playback: {8,2},{8,1}, vol 4
    rom_c[0] = 20'd8; rom_d[0] = 8'd2;
    rom_c[1] = 20'd8; rom_d[1] = 8'd1;
    song_len = 10'd2;
    d0 = done_seen;
    start();
    check("n_busy", {31'd0, busy}, 32'd1);
    check("n_addr0", 32'(rom_addr), 32'd0);
    tick(); tick();
    check("n_pre_tone", {31'd0, buzzer}, 32'd1);
    tone(200, 8, 4, 0, "n_note0");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("n_gap0", {31'd0, buzzer}, 32'd1);
    end
    check("n_addr1", 32'(rom_addr), 32'd1);
    tick(); tick();
    check("n_pre_tone1", {31'd0, buzzer}, 32'd1);
    tone(100, 8, 4, 0, "n_note1");
    finish_song("n");
    check("n_done_cnt", 32'(done_seen - d0), 32'd1);

    // Pause mid-note for 50 cycles at a low phase
    rom_c[0] = 20'd8; rom_d[0] = 8'd2;
    song_len = 10'd1;
    start();
    tick(); tick();
    tone(16, 8, 4, 0, "p_pre");
    run = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("p_pause_buz", {31'd0, buzzer}, 32'd1);
    end
    run = 1'b1;
    tone(184, 8, 4, 16, "p_resume");
    finish_song("p");

    // Rest {0,1}, skip {8,0}, then {8,1} at vol 3 (low 2 of 8)
    rom_c[0] = 20'd0; rom_d[0] = 8'd1;
    rom_c[1] = 20'd8; rom_d[1] = 8'd0;
    rom_c[2] = 20'd8; rom_d[2] = 8'd1;
    song_len = 10'd3;
    vol = 3'd3;
    start();
    tick(); tick();
    for (int i = 0; i < 110; i++) begin
      tick();
      check("r_rest_buz", {31'd0, buzzer}, 32'd1);
    end
    check("r_addr1", 32'(rom_addr), 32'd1);
    tick(); tick();
    check("r_skip_addr2", 32'(rom_addr), 32'd2);
    check("r_skip_buz", {31'd0, buzzer}, 32'd1);
    tick(); tick();
    check("r_pre_tone", {31'd0, buzzer}, 32'd1);
    tone(100, 8, 2, 0, "r_vol3");
    finish_song("r");

    // Loop: wrap once, then clear loop_en and finish
    rom_c[0] = 20'd8; rom_d[0] = 8'd1;
    rom_c[1] = 20'd8; rom_d[1] = 8'd1;
    song_len = 10'd2;
    vol = 3'd4;
    loop_en = 1'b1;
    d0 = done_seen;
    w0 = wrap_seen;
    start();
    repeat (112) tick();
    check("l_addr1", 32'(rom_addr), 32'd1);
    repeat (111) tick();
    check("l_prewrap", {31'd0, song_wrap}, 32'd0);
    check("l_prewrap_addr", 32'(rom_addr), 32'd1);
    tick();
    check("l_wrap", {31'd0, song_wrap}, 32'd1);
    check("l_wrap_addr", 32'(rom_addr), 32'd0);
    check("l_wrap_nodone", {31'd0, play_done}, 32'd0);
    check("l_wrap_busy", {31'd0, busy}, 32'd1);
    tick();
    check("l_wrap_pulse", {31'd0, song_wrap}, 32'd0);
    loop_en = 1'b0;
    repeat (222) tick();
    check("l_predone", {31'd0, play_done}, 32'd0);
    tick();
    check("l_done", {31'd0, play_done}, 32'd1);
    check("l_done_nowrap", {31'd0, song_wrap}, 32'd0);
    tick();
    check("l_idle", {31'd0, busy}, 32'd0);
    check("l_wrap_cnt", 32'(wrap_seen - w0), 32'd1);
    check("l_done_cnt", 32'(done_seen - d0), 32'd1);

    // Abort during note 1 with a simultaneous play_en
    rom_c[0] = 20'd8; rom_d[0] = 8'd1;
    rom_c[1] = 20'd8; rom_d[1] = 8'd2;
    song_len = 10'd2;
    d0 = done_seen;
    start();
    repeat (149) tick();
    check("a_addr1", 32'(rom_addr), 32'd1);
    check("a_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    play_en = 1'b1;
    tick();
    stop = 1'b0;
    play_en = 1'b0;
    check("a_idle", {31'd0, busy}, 32'd0);
    check("a_addr0", 32'(rom_addr), 32'd0);
    check("a_buz", {31'd0, buzzer}, 32'd1);
    check("a_nodone", {31'd0, play_done}, 32'd0);
    repeat (3) tick();
    check("a_stay_idle", {31'd0, busy}, 32'd0);
    check("a_done_cnt", 32'(done_seen - d0), 32'd0);

    // vol 1, cycle 32 -> 32>>4 = 2 low cycles per period
    rom_c[0] = 20'd32; rom_d[0] = 8'd1;
    song_len = 10'd1;
    vol = 3'd1;
    start();
    tick(); tick();
    tone(100, 32, 2, 0, "v_vol1");
    finish_song("v1");

    // vol 5 saturates to 1/2 duty
    rom_c[0] = 20'd8; rom_d[0] = 8'd1;
    vol = 3'd5;
    start();
    tick(); tick();
    tone(100, 8, 4, 0, "v_vol5");
    finish_song("v5");

    // vol 0 mutes but the note still lasts 100 cycles
    vol = 3'd0;
    start();
    for (int i = 0; i < 111; i++) begin
      tick();
      check("v_mute_buz", {31'd0, buzzer}, 32'd1);
    end
    tick();
    check("v_mute_done", {31'd0, play_done}, 32'd1);
    tick();
    vol = 3'd4;

    // Empty song
    song_len = 10'd0;
    start();
    check("e_done", {31'd0, play_done}, 32'd1);
    check("e_busy", {31'd0, busy}, 32'd1);
    check("e_buz", {31'd0, buzzer}, 32'd1);
    check("e_addr", 32'(rom_addr), 32'd0);
    tick();
    check("e_done_off", {31'd0, play_done}, 32'd0);
    check("e_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-note (note 1, buzzer low phase)
    rom_c[0] = 20'd8; rom_d[0] = 8'd1;
    rom_c[1] = 20'd8; rom_d[1] = 8'd2;
    song_len = 10'd2;
    start();
    repeat (131) tick();
    check("x_pre_buz", {31'd0, buzzer}, 32'd0);
    check("x_pre_addr", 32'(rom_addr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("x_buz", {31'd0, buzzer}, 32'd1);
    check("x_busy", {31'd0, busy}, 32'd0);
    check("x_addr", 32'(rom_addr), 32'd0);
    check("x_done", {31'd0, play_done}, 32'd0);
    check("x_wrap", {31'd0, song_wrap}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("x_after_busy", {31'd0, busy}, 32'd0);
    check("x_after_buz", {31'd0, buzzer}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
